// File: rtl/input_conditioner_if.sv
// Pad-side inputs and debounced outputs of the switch/button front end.
interface input_conditioner_if #(
  parameter int SW_WIDTH = 16
);
  logic [SW_WIDTH-1:0] sw_raw;
  logic                btn_raw;
  logic                confirm_clr;
  logic [SW_WIDTH-1:0] switch_stable;
  logic                btn_level;
  logic                confirmation;
  logic                press_pulse;

  modport master (
    output sw_raw, btn_raw, confirm_clr,
    input  switch_stable, btn_level, confirmation, press_pulse
  );

  modport slave (
    input  sw_raw, btn_raw, confirm_clr,
    output switch_stable, btn_level, confirmation, press_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise and debounce switch/button pads and keep a sticky confirmation flag.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES clocks from pad to output; free-running, no backpressure.
module input_conditioner #(
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   bus
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

  logic [SW_WIDTH:0]   sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0] sw_sync, sw_prev_q, stable_q, stable_d;
  logic                btn_sync;
  logic [CW-1:0]       sw_cnt_q, sw_cnt_d, sw_cnt_nxt;
  logic [CW-1:0]       btn_cnt_q, btn_cnt_d, btn_cnt_inc;
  btn_state_t          state_q, state_d;
  logic                level_q, level_d, pulse_q, pulse_d, confirm_q, confirm_d;

  // Button rides in the MSB of the shared synchroniser chain.
  assign sw_sync     = sync_q[SYNC_STAGES-1][SW_WIDTH-1:0];
  assign btn_sync    = sync_q[SYNC_STAGES-1][SW_WIDTH];
  assign btn_cnt_inc = btn_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.btn_raw, bus.sw_raw};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // The cycle on which a new value first shows up counts as debounce cycle zero.
  always_comb begin
    stable_d   = stable_q;
    sw_cnt_d   = '0;
    sw_cnt_nxt = '0;
    if (sw_sync != stable_q) begin
      sw_cnt_nxt = (sw_sync != sw_prev_q) ? '0 : sw_cnt_q + 1'b1;
      if (sw_cnt_nxt >= LAST) begin
        stable_d = sw_sync;
      end else begin
        sw_cnt_d = sw_cnt_nxt;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    btn_cnt_d = btn_cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d   = PRESS_WAIT;
          btn_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = RELEASED;
        end else if (btn_cnt_inc >= LAST) begin
          state_d   = PRESSED;
          level_d   = 1'b1;
          pulse_d   = 1'b1;
          btn_cnt_d = '0;
        end else begin
          btn_cnt_d = btn_cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d   = RELEASE_WAIT;
          btn_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (btn_cnt_inc >= LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          btn_cnt_d = '0;
        end else begin
          btn_cnt_d = btn_cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
    // A press arriving with a clear must not be lost, so set dominates.
    confirm_d = pulse_d | (confirm_q & ~bus.confirm_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev_q <= '0;
      stable_q  <= '0;
      sw_cnt_q  <= '0;
      btn_cnt_q <= '0;
      state_q   <= RELEASED;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      sw_prev_q <= sw_sync;
      stable_q  <= stable_d;
      sw_cnt_q  <= sw_cnt_d;
      btn_cnt_q <= btn_cnt_d;
      state_q   <= state_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      confirm_q <= confirm_d;
    end
  end

  assign bus.switch_stable = stable_q;
  assign bus.btn_level     = level_q;
  assign bus.confirmation  = confirm_q;
  assign bus.press_pulse   = pulse_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst;

  input_conditioner_if #(.SW_WIDTH(16)) bus ();

  input_conditioner #(
    .SW_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sw;
    logic        lvl;
    logic        conf;
    logic        pulse;
  } out_t;

  typedef struct {
    logic        rst;
    logic [15:0] sw;
    logic        btn;
    logic        clr;
    out_t        exp;
    string       name;
  } vec_t;

  out_t  sb_q[$];
  string name_q[$];
  vec_t  vecs[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic out_t mk(input logic [15:0] sw, input logic lvl, input logic conf, input logic pulse);
    out_t o;
    o.sw = sw; o.lvl = lvl; o.conf = conf; o.pulse = pulse;
    return o;
  endfunction

  function automatic vec_t v(input logic r, input logic [15:0] sw, input logic btn, input logic clr,
                             input out_t exp, input string name);
    vec_t x;
    x.rst = r; x.sw = sw; x.btn = btn; x.clr = clr; x.exp = exp; x.name = name;
    return x;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare just after the edge.
  task automatic step(input logic r, input logic [15:0] sw, input logic btn, input logic clr,
                      input out_t exp, input string name);
    out_t  act, e;
    string nm;
    rst             = r;
    bus.sw_raw      = sw;
    bus.btn_raw     = btn;
    bus.confirm_clr = clr;
    sb_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    act = {bus.switch_stable, bus.btn_level, bus.confirmation, bus.press_pulse};
    e   = sb_q.pop_front();
    nm  = name_q.pop_front();
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got sw=%h lvl=%b conf=%b pulse=%b, expected sw=%h lvl=%b conf=%b pulse=%b",
               nm, $time, act.sw, act.lvl, act.conf, act.pulse, e.sw, e.lvl, e.conf, e.pulse);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1);
  end

  initial begin
    // Reset, latency, glitch rejection and idle clear.
    vecs.push_back(v(1, 16'hA5C3, 0, 0, mk(16'h0000, 0, 0, 0), "reset"));
    vecs.push_back(v(1, 16'hA5C3, 0, 0, mk(16'h0000, 0, 0, 0), "reset"));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(v(0, 16'hA5C3, 0, 0, mk(16'h0000, 0, 0, 0), "sw_latency_wait"));
    vecs.push_back(v(0, 16'hA5C3, 0, 0, mk(16'hA5C3, 0, 0, 0), "sw_latency_6th"));
    vecs.push_back(v(0, 16'hA5C3, 0, 0, mk(16'hA5C3, 0, 0, 0), "sw_hold"));
    vecs.push_back(v(0, 16'hA5C3, 0, 1, mk(16'hA5C3, 0, 0, 0), "clr_when_idle"));
    for (int i = 1; i <= 2; i++)
      vecs.push_back(v(0, 16'hA5C2, 0, 0, mk(16'hA5C3, 0, 0, 0), "glitch2"));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(0, 16'hA5C3, 0, 0, mk(16'hA5C3, 0, 0, 0), "glitch2_after"));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(v(0, 16'hA5C2, 0, 0, mk(16'hA5C3, 0, 0, 0), "glitch3"));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(0, 16'hA5C3, 0, 0, mk(16'hA5C3, 0, 0, 0), "glitch3_after"));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(v(0, 16'h1234, 0, 0, mk(16'hA5C3, 0, 0, 0), "sw_change_wait"));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(v(0, 16'h1234, 0, 0, mk(16'h1234, 0, 0, 0), "sw_change_done"));

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].sw, vecs[i].btn, vecs[i].clr, vecs[i].exp, vecs[i].name);

    // Clean press: one pulse on the 6th edge, no repeats while held.
    for (int k = 1; k <= 20; k++)
      step(0, 16'h1234, 1, 0, mk(16'h1234, k >= 6, k >= 6, k == 6), "press_hold");
    for (int k = 1; k <= 8; k++)
      step(0, 16'h1234, 0, 0, mk(16'h1234, k < 6, 1, 0), "release");

    step(0, 16'h1234, 0, 1, mk(16'h1234, 0, 0, 0), "clr");
    step(0, 16'h1234, 0, 0, mk(16'h1234, 0, 0, 0), "clr_stays");

    // Clear on the accept edge loses to the set.
    for (int k = 1; k <= 8; k++)
      step(0, 16'h1234, 1, k == 6, mk(16'h1234, k >= 6, k >= 6, k == 6), "clr_coincident");
    step(0, 16'h1234, 1, 1, mk(16'h1234, 1, 0, 0), "clr_while_held");
    for (int k = 1; k <= 6; k++)
      step(0, 16'h1234, 1, 0, mk(16'h1234, 1, 0, 0), "no_repeat");
    for (int k = 1; k <= 8; k++)
      step(0, 16'h1234, 0, 0, mk(16'h1234, k < 6, 0, 0), "release2");

    // Bounce 1,0,1,0 then steady.
    for (int k = 1; k <= 4; k++)
      step(0, 16'h1234, (k % 2) == 1, 0, mk(16'h1234, 0, 0, 0), "bounce");
    for (int k = 1; k <= 10; k++)
      step(0, 16'h1234, 1, 0, mk(16'h1234, k >= 6, k >= 6, k == 6), "bounce_steady");
    for (int k = 1; k <= 8; k++)
      step(0, 16'h1234, 0, 0, mk(16'h1234, k < 6, 1, 0), "release3");

    // Reset mid-debounce, then full re-debounce of button and switches.
    for (int k = 1; k <= 5; k++)
      step(0, 16'h1234, 1, 0, mk(16'h1234, 0, 1, 0), "pre_rst");
    step(1, 16'h1234, 1, 0, mk(16'h0000, 0, 0, 0), "mid_rst");
    for (int k = 1; k <= 8; k++)
      step(0, 16'h1234, 1, 0, mk((k >= 6) ? 16'h1234 : 16'h0000, k >= 6, k >= 6, k == 6), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
